// File: rtl/rr_grant_ctl.sv
// ============================================================================
// Module   : rr_grant_ctl
// Purpose  : Four-way round-robin grant controller with a watchdog on tenure
//            and one dead cycle between owners.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_grant_ctl #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic [3:0] done,
  output logic [3:0] grant,
  output logic [1:0] grant_id,
  output logic       busy,
  output logic       timeout
);

  localparam logic [7:0] c_timeout = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_grant, w_grant_nxt;
  logic [1:0] r_grant_id, w_grant_id_nxt;
  logic       r_busy;
  logic       r_timeout, w_timeout_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic [1:0] r_last, w_last_nxt;

  logic [1:0] w_winner;
  logic       w_any_req;
  logic       w_own_done;
  logic       w_own_req;
  logic       w_expired;

  // Rotating priority: first set request at or after last+1, wrapping.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    w_winner = r_last;
    found    = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = r_last + 2'(i);
      if (!found && req[idx]) begin
        w_winner = idx;
        found    = 1'b1;
      end
    end
  end

  assign w_any_req  = |req;
  assign w_own_done = done[r_grant_id];
  assign w_own_req  = req[r_grant_id];
  assign w_expired  = (r_cnt == c_timeout);

  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_grant_id_nxt = r_grant_id;
    w_timeout_nxt  = 1'b0;
    w_cnt_nxt      = r_cnt;
    w_last_nxt     = r_last;
    case (r_state)
      S_IDLE, S_RELEASE: begin
        w_grant_nxt = 4'b0000;
        if (w_any_req) begin
          w_state_nxt    = S_GRANT;
          w_grant_nxt    = 4'b0001 << w_winner;
          w_grant_id_nxt = w_winner;
          w_cnt_nxt      = 8'd1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_GRANT: begin
        if (w_own_done || !w_own_req || w_expired) begin
          w_state_nxt   = S_RELEASE;
          w_grant_nxt   = 4'b0000;
          w_last_nxt    = r_grant_id;
          // A completion in the final cycle wins over the watchdog.
          w_timeout_nxt = w_expired && !w_own_done;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt    = S_IDLE;
        w_grant_nxt    = 4'b0000;
        w_grant_id_nxt = 2'd0;
        w_cnt_nxt      = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_grant    <= 4'b0000;
      r_grant_id <= 2'd0;
      r_busy     <= 1'b0;
      r_timeout  <= 1'b0;
      r_cnt      <= 8'd0;
      r_last     <= 2'd3;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_grant_id <= w_grant_id_nxt;
      r_busy     <= |w_grant_nxt;
      r_timeout  <= w_timeout_nxt;
      r_cnt      <= w_cnt_nxt;
      r_last     <= w_last_nxt;
    end
  end

  assign grant    = r_grant;
  assign grant_id = r_grant_id;
  assign busy     = r_busy;
  assign timeout  = r_timeout;

endmodule

`default_nettype wire
